// File: rtl/irq_ctrl.sv
// Machine-level interrupt controller: mip/mie state, 64-bit mtime/mtimecmp timer,
// external-line synchronizer and a req/ack sequencer into the XB-stage exception path.
module irq_ctrl #(
    parameter int unsigned PRESCALE    = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        ext_irq_in,
    input  logic        sw_irq_set,
    input  logic        sw_irq_clr,
    input  logic        cmp_we,
    input  logic        cmp_hi,
    input  logic [31:0] cmp_wdata,
    input  logic        mie_we,
    input  logic [31:0] mie_wdata,
    input  logic        global_mie,
    input  logic        XB_bubble,
    input  logic        exc_in,
    input  logic        irq_ack,
    output logic        irq_req,
    output logic [31:0] irq_cause,
    output logic [31:0] mip_out,
    output logic [31:0] mie_out,
    output logic [63:0] mtime_out
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BLOCK
    } state_t;

    state_t                 r_state;
    logic [PW-1:0]          r_presc;
    logic [63:0]            r_mtime;
    logic [63:0]            r_mtimecmp;
    logic                   r_mtip;
    logic                   r_msip;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_mie_e;
    logic                   r_mie_t;
    logic                   r_mie_s;
    logic [31:0]            r_cause;

    logic                   w_meip;
    logic [2:0]             w_pend;
    logic [3:0]             w_code;
    logic                   w_unused_mie;

    assign w_meip       = r_sync[SYNC_STAGES-1];
    assign w_unused_mie = &{1'b0, mie_wdata[31:12], mie_wdata[10:8], mie_wdata[6:4], mie_wdata[2:0]};

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_presc <= '0;
            r_mtime <= '0;
        end else if (r_presc == PRESC_MAX) begin
            r_presc <= '0;
            r_mtime <= r_mtime + 64'd1;
        end else begin
            r_presc <= r_presc + PRESC_ONE;
        end
    end

    // MTIP compares the registered values, so a compare write shows up two cycles later.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_mtimecmp <= '1;
            r_mtip     <= 1'b0;
        end else begin
            r_mtip <= (r_mtime >= r_mtimecmp);
            if (cmp_we) begin
                if (cmp_hi) begin
                    r_mtimecmp[63:32] <= cmp_wdata;
                end else begin
                    r_mtimecmp[31:0] <= cmp_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_msip  <= 1'b0;
            r_sync  <= '0;
            r_mie_e <= 1'b0;
            r_mie_t <= 1'b0;
            r_mie_s <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ext_irq_in};
            if (sw_irq_set) begin
                r_msip <= 1'b1;
            end else if (sw_irq_clr) begin
                r_msip <= 1'b0;
            end
            if (mie_we) begin
                r_mie_e <= mie_wdata[11];
                r_mie_t <= mie_wdata[7];
                r_mie_s <= mie_wdata[3];
            end
        end
    end

    // Pending bits ordered {MEI, MSI, MTI}, which is also the priority order.
    assign w_pend = {w_meip & r_mie_e, r_msip & r_mie_s, r_mtip & r_mie_t};

    always_comb begin
        w_code = 4'd0;
        if (w_pend[2]) begin
            w_code = 4'd11;
        end else if (w_pend[1]) begin
            w_code = 4'd3;
        end else if (w_pend[0]) begin
            w_code = 4'd7;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state <= IDLE;
            r_cause <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (global_mie && (w_pend != 3'b000)) begin
                        r_state <= REQ;
                        r_cause <= {1'b1, 27'b0, w_code};
                    end
                end
                REQ: begin
                    if (irq_ack && !exc_in) begin
                        r_state <= BLOCK;
                    end else if (!global_mie || (w_pend == 3'b000)) begin
                        r_state <= IDLE;
                    end
                end
                BLOCK: begin
                    if (!global_mie) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Synchronous exceptions and XB bubbles mask the request without leaving REQ.
    assign irq_req   = (r_state == REQ) && !exc_in && !XB_bubble;
    assign irq_cause = r_cause;
    assign mip_out   = {20'b0, w_meip, 3'b0, r_mtip, 3'b0, r_msip, 3'b0};
    assign mie_out   = {20'b0, r_mie_e, 3'b0, r_mie_t, 3'b0, r_mie_s, 3'b0};
    assign mtime_out = r_mtime;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: expected interrupt causes are queued when the
// triggering stimulus is applied and popped when the controller raises irq_req.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        resetb;
    logic        ext_irq_in;
    logic        sw_irq_set;
    logic        sw_irq_clr;
    logic        cmp_we;
    logic        cmp_hi;
    logic [31:0] cmp_wdata;
    logic        mie_we;
    logic [31:0] mie_wdata;
    logic        global_mie;
    logic        XB_bubble;
    logic        exc_in;
    logic        irq_ack;
    logic        irq_req;
    logic [31:0] irq_cause;
    logic [31:0] mip_out;
    logic [31:0] mie_out;
    logic [63:0] mtime_out;

    int          testsRun    = 0;
    int          testsFailed = 0;
    int          cycles      = 0;
    logic [31:0] expQ[$];

    irq_ctrl #(
        .PRESCALE    (1),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .ext_irq_in (ext_irq_in),
        .sw_irq_set (sw_irq_set),
        .sw_irq_clr (sw_irq_clr),
        .cmp_we     (cmp_we),
        .cmp_hi     (cmp_hi),
        .cmp_wdata  (cmp_wdata),
        .mie_we     (mie_we),
        .mie_wdata  (mie_wdata),
        .global_mie (global_mie),
        .XB_bubble  (XB_bubble),
        .exc_in     (exc_in),
        .irq_ack    (irq_ack),
        .irq_req    (irq_req),
        .irq_cause  (irq_cause),
        .mip_out    (mip_out),
        .mie_out    (mie_out),
        .mtime_out  (mtime_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
        cycles++;
    endtask

    task automatic applyStimulus(input logic mieWe, input logic [31:0] mieData,
                                 input logic cmpWe, input logic cmpHi, input logic [31:0] cmpData,
                                 input logic swSet, input logic swClr);
        mie_we     = mieWe;
        mie_wdata  = mieData;
        cmp_we     = cmpWe;
        cmp_hi     = cmpHi;
        cmp_wdata  = cmpData;
        sw_irq_set = swSet;
        sw_irq_clr = swClr;
        stepClock();
        mie_we     = 1'b0;
        cmp_we     = 1'b0;
        sw_irq_set = 1'b0;
        sw_irq_clr = 1'b0;
    endtask

    task automatic awaitRequest(input string tag, input int budget);
        logic [31:0] exp;
        for (int i = 0; i < budget && !irq_req; i++) begin
            stepClock();
        end
        checkOutput({tag, "_req"}, 64'(irq_req), 64'd1);
        exp = (expQ.size() > 0) ? expQ.pop_front() : 32'h0;
        checkOutput({tag, "_cause"}, 64'(irq_cause), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic sticky;
        resetb     = 1'b0;
        ext_irq_in = 1'b0;
        sw_irq_set = 1'b0;
        sw_irq_clr = 1'b0;
        cmp_we     = 1'b0;
        cmp_hi     = 1'b0;
        cmp_wdata  = '0;
        mie_we     = 1'b0;
        mie_wdata  = '0;
        global_mie = 1'b0;
        XB_bubble  = 1'b0;
        exc_in     = 1'b0;
        irq_ack    = 1'b0;
        repeat (3) stepClock();
        checkOutput("rst_req", 64'(irq_req), 64'd0);
        checkOutput("rst_cause", 64'(irq_cause), 64'd0);
        checkOutput("rst_mtime", mtime_out, 64'd0);
        checkOutput("rst_mie", 64'(mie_out), 64'd0);
        checkOutput("rst_mip", 64'(mip_out), 64'd0);
        resetb = 1'b1;
        cycles = 0;

        // Timer interrupt: mtimecmp = 5, only MTIE enabled
        expQ.push_back(32'h8000_0007);
        global_mie = 1'b1;
        applyStimulus(1'b1, 32'h0000_0080, 1'b1, 1'b0, 32'd5, 1'b0, 1'b0);
        checkOutput("mie_store", 64'(mie_out), 64'h80);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0);
        checkOutput("mtime_count_a", mtime_out, 64'(cycles));
        for (int i = 0; i < 20 && mtime_out != 64'd5; i++) begin
            stepClock();
        end
        checkOutput("mtime_at_5", mtime_out, 64'd5);
        checkOutput("mtip_pre", 64'(mip_out), 64'h0);
        stepClock();
        checkOutput("mtip_rise", 64'(mip_out), 64'h80);
        checkOutput("req_latency", 64'(irq_req), 64'd0);
        stepClock();
        awaitRequest("req_mti", 0);

        // Ack then hold global_mie: controller must stay quiet in BLOCK
        irq_ack = 1'b1;
        stepClock();
        irq_ack = 1'b0;
        checkOutput("ack_drop", 64'(irq_req), 64'd0);
        sticky = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stepClock();
            sticky = sticky | irq_req;
        end
        checkOutput("block_hold", 64'(sticky), 64'd0);
        global_mie = 1'b0;
        stepClock();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        checkOutput("cmp_lag", 64'(mip_out), 64'h80);
        stepClock();
        checkOutput("mtip_clear", 64'(mip_out), 64'h0);

        // MEI and MSI raised together; MEI wins
        applyStimulus(1'b1, 32'h0000_0888, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("mie_all", 64'(mie_out), 64'h888);
        ext_irq_in = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("meip_sync1", 64'(mip_out), 64'h008);
        stepClock();
        checkOutput("meip_sync2", 64'(mip_out), 64'h808);
        expQ.push_back(32'h8000_000B);
        global_mie = 1'b1;
        stepClock();
        awaitRequest("req_mei", 0);

        // Synchronous exception masks the request and swallows the ack
        exc_in  = 1'b1;
        irq_ack = 1'b1;
        #1;
        checkOutput("exc_mask", 64'(irq_req), 64'd0);
        stepClock();
        checkOutput("exc_mask_hold", 64'(irq_req), 64'd0);
        exc_in  = 1'b0;
        irq_ack = 1'b0;
        #1;
        checkOutput("exc_resume", 64'(irq_req), 64'd1);
        checkOutput("cause_hold", 64'(irq_cause), 64'h8000_000B);
        XB_bubble = 1'b1;
        #1;
        checkOutput("bubble_mask", 64'(irq_req), 64'd0);
        XB_bubble = 1'b0;
        irq_ack   = 1'b1;
        stepClock();
        irq_ack = 1'b0;
        checkOutput("ack_mei", 64'(irq_req), 64'd0);

        // Return to IDLE with MEIP low: MSI is next
        ext_irq_in = 1'b0;
        global_mie = 1'b0;
        repeat (3) stepClock();
        checkOutput("meip_fall", 64'(mip_out), 64'h008);
        expQ.push_back(32'h8000_0003);
        global_mie = 1'b1;
        stepClock();
        awaitRequest("req_msi", 0);

        // Withdraw without ack, then re-request from IDLE
        global_mie = 1'b0;
        stepClock();
        checkOutput("withdraw", 64'(irq_req), 64'd0);
        expQ.push_back(32'h8000_0003);
        global_mie = 1'b1;
        stepClock();
        awaitRequest("rereq", 0);
        ext_irq_in = 1'b1;
        repeat (3) stepClock();
        checkOutput("cause_latched", 64'(irq_cause), 64'h8000_0003);

        // Asynchronous reset mid-handshake
        resetb = 1'b0;
        #1;
        checkOutput("arst_req", 64'(irq_req), 64'd0);
        checkOutput("arst_cause", 64'(irq_cause), 64'd0);
        checkOutput("arst_mtime", mtime_out, 64'd0);
        checkOutput("arst_mip", 64'(mip_out), 64'd0);
        checkOutput("arst_mie", 64'(mie_out), 64'd0);
        ext_irq_in = 1'b0;
        global_mie = 1'b0;
        stepClock();
        resetb = 1'b1;
        cycles = 0;
        applyStimulus(1'b1, 32'h0000_0080, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (5) stepClock();
        checkOutput("mtime_count_b", mtime_out, 64'(cycles));
        checkOutput("cmp_reset_ones", 64'(mip_out), 64'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("set_wins", 64'(mip_out), 64'h008);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("msip_clr", 64'(mip_out), 64'h0);

        checkOutput("sb_empty", 64'(expQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Machine-level interrupt controller for the RV32I pipeline. It holds the mip/mie interrupt bits, a 64-bit mtime/mtimecmp timer, a synchronizer for the external interrupt line and the software-interrupt flag.
- It prioritizes pending-and-enabled interrupts and sequences an interrupt request into the XB-stage exception path through a req/ack handshake. The request is masked by synchronous exceptions raised in the same stage.

Parameters:
PRESCALE, 1, mtime increments once every PRESCALE clk cycles (≥1).
SYNC_STAGES, 2, flip-flop stages on ext_irq_in (≥2).

Ports:
clk  in  1  clock
resetb  in  1  reset; asynchronous, active-low
ext_irq_in  in  1  external interrupt level, asynchronous to clk
sw_irq_set  in  1  set MSIP (one-cycle pulse)
sw_irq_clr  in  1  clear MSIP (one-cycle pulse)
cmp_we  in  1  write mtimecmp half
cmp_hi  in  1  1 = write bits [63:32], 0 = write bits [31:0]
cmp_wdata  in  32  mtimecmp write data
mie_we  in  1  write mie register
mie_wdata  in  32  mie write data; only bits 3, 7, 11 are stored
global_mie  in  1  mstatus.MIE from csr_ehu
XB_bubble  in  1  XB stage holds a bubble
exc_in  in  1  synchronous exception initiating (csr_ehu initiate_exception)
irq_ack  in  1  pipeline took the interrupt trap this cycle
irq_req  out  1  interrupt trap requested
irq_cause  out  32  mcause value for the requested interrupt
mip_out  out  32  {20'b0, MEIP, 3'b0, MTIP, 3'b0, MSIP, 3'b0}
mie_out  out  32  stored mie bits at positions 11, 7, 3; all other bits 0
mtime_out  out  64  current mtime

Behaviour:
- Reset values:
  - mtime = 0, prescaler = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - MSIP = 0, mie = 0, synchronizer flops = 0.
  - FSM in IDLE, irq_req = 0, irq_cause = 0.
  - Reset asserted mid-handshake returns every register above to these values immediately.
- Timer:
  - Prescaler counts 0..PRESCALE-1. mtime increments by 1 when the prescaler equals PRESCALE-1, then the prescaler wraps to 0.
  - mtime wraps from 2^64-1 to 0.
  - MTIP is registered: MTIP = (mtime ≥ mtimecmp), unsigned 64-bit, evaluated on the current register values.
  - A cmp_we write takes effect the next cycle; MTIP reflects the new value one cycle after that.
- MEIP = last synchronizer stage, i.e. SYNC_STAGES-cycle latency from ext_irq_in.
- MSIP update:
  - sw_irq_set sets it, sw_irq_clr clears it.
  - If both are asserted in the same cycle, set wins.
- mie_we stores mie_wdata[11], [7] and [3]; the new value is visible on mie_out the next cycle.
- Pending selection: pend = mip & mie, using bits 11, 7, 3. Fixed priority MEI(11) > MSI(3) > MTI(7).
- Cause encoding: cause = {1'b1, 27'b0, code}, with code = 11, 3 or 7 respectively.
- FSM states: IDLE, REQ, BLOCK.
  - IDLE → REQ when global_mie=1 and pend≠0. Latch irq_cause from the highest-priority pending bit.
  - REQ: irq_cause is held stable.
    - irq_req = ~exc_in, combinational mask, so synchronous exceptions win.
    - If irq_ack=1 and exc_in=0 → BLOCK.
    - irq_ack while exc_in=1 is ignored; stay in REQ.
    - If global_mie=0 or pend=0 without an ack, the request is withdrawn → IDLE, irq_req=0 next cycle.
    - A higher-priority source arriving while in REQ does not change the latched cause.
  - BLOCK: irq_req=0; wait for csr_ehu to clear mstatus.MIE. BLOCK → IDLE when global_mie=0.
- The controller never asserts irq_req while XB_bubble=1.
- irq_ack outside REQ is ignored.
- Level sources are not cleared by the controller: MTIP clears via an mtimecmp write, MSIP via sw_irq_clr, MEIP at the source.

Test Plan:
- Reset, then mie_we with bit 7 set, cmp_wdata lo=5 / hi=0, global_mie=1, PRESCALE=1 → MTIP rises when mtime=5. irq_req=1 with irq_cause=0x80000007 one cycle later.
- mie={11,3,7} enabled, MSIP and MEIP raised in the same cycle → irq_cause=0x8000000B. After ack, global_mie drop and return to 1 with MEIP low → next request irq_cause=0x80000003.
- In REQ, assert exc_in with irq_ack=1 → irq_req=0 that cycle, state stays REQ. Drop exc_in → irq_req=1 again with the same cause.
- In REQ, drop global_mie with no ack → irq_req=0 the next cycle, FSM in IDLE.
- After ack with global_mie held at 1 for 10 cycles → irq_req stays 0 (BLOCK). global_mie=0 → IDLE.
- Pulse resetb low while irq_req=1 → irq_req=0 immediately, mtimecmp=all ones, mtime=0. sw_irq_set and sw_irq_clr in the same cycle → MSIP=1.
